dsram_responder: RTL

Data-side SRAM-like responder. It accepts load/store requests from the CPU's EX stage over the req/addr_ok handshake and returns in-order data_ok/rdata responses, which the MEM stage consumes. A word-organised on-chip memory backs the responses. A programmable minimum latency and a bounded outstanding-request queue let the pipeline's wait/forward logic be exercised against realistic timing.

---
 rtl/dsram_responder.sv | 73 +++++++
 1 files changed

// File: rtl/dsram_responder.sv
// dsram_responder: word-organised data SRAM responder with in-order responses,
// programmable minimum latency and a bounded outstanding-request queue.
module dsram_responder #(
    parameter int MEM_AW = 12,
    parameter int LAT    = 2,
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic        addr_stall,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [2:0] LAT3 = 3'(LAT);

    logic [31:0]        mem [2**MEM_AW];
    logic [QDEPTH-1:0]  q_valid;
    logic [QDEPTH-1:0]  q_load;
    logic [31:0]        q_data [QDEPTH];
    logic [2:0]         q_age [QDEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [PW:0]        count;
    logic [MEM_AW-1:0]  word;
    logic               accept;
    logic               unused;

    assign word    = addr[MEM_AW+1:2];
    assign unused  = ^{size, addr[31:MEM_AW+2], addr[1:0]};
    // count never exceeds QDEPTH (a power of two), so its MSB alone marks full
    assign addr_ok = !reset && !addr_stall && !count[PW];
    assign accept  = req && addr_ok;
    assign data_ok = q_valid[head] && (q_age[head] >= LAT3);
    assign rdata   = (data_ok && q_load[head]) ? q_data[head] : '0;

    always_ff @(posedge clk)
        if (accept && wr)
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[word][8*b +: 8] <= wdata[8*b +: 8];

    // A new entry starts at age 1 so that the head can respond exactly LAT cycles after acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++)
                q_age[i] <= (q_age[i] != LAT3) ? q_age[i] + 3'd1 : q_age[i];
            if (data_ok) begin
                q_valid[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            if (accept) begin
                q_valid[tail] <= 1'b1;
                q_load[tail]  <= !wr;
                q_data[tail]  <= wr ? '0 : mem[word];
                q_age[tail]   <= 3'd1;
                tail          <= tail + 1'b1;
            end
            count <= count + (PW+1)'(accept) - (PW+1)'(data_ok);
        end
    end
endmodule
